// File: rtl/uart_tx_cfg_pkg.sv
// Shared encodings, FSM states and the per-frame configuration snapshot for the
// configurable UART transmitter (the future receiver reuses the same encodings).
package uart_tx_cfg_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    localparam int unsigned DBITS_MIN = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Frame format captured together with the data at write time
    typedef struct packed {
        logic [3:0] dbits;
        logic       par_en;
        logic       par_bit;
        logic [1:0] stop;
    } frame_cfg_t;

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register: accepts writes while empty, flags dropped writes,
// clamps the data width and precomputes the parity bit of the held frame.
module uart_tx_hold
    import uart_tx_cfg_pkg::*;
#(
    parameter int unsigned DBIT_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic [1:0]          cfg_stop,
    input  logic [DBIT_MAX-1:0] din,
    input  logic                drain,
    output logic                hold_valid_c,
    output logic [DBIT_MAX-1:0] hold_data,
    output frame_cfg_t          hold_cfg,
    output logic                tx_ready,
    output logic                tx_ovf_tick
);

    logic [3:0] dbits_c;
    logic       par_en_c;
    logic       par_odd_c;
    frame_cfg_t cfg_c;

    // XOR of the low nb data bits
    function automatic logic data_xor(input logic [DBIT_MAX-1:0] d, input logic [3:0] nb);
        logic x;
        x = 1'b0;
        for (int i = 0; i < int'(DBIT_MAX); i++) begin
            if (4'(i) < nb) x = x ^ d[i];
        end
        return x;
    endfunction

    always_comb begin
        dbits_c   = cfg_dbits;
        par_en_c  = 1'b0;
        par_odd_c = 1'b0;
        if (32'(cfg_dbits) < DBITS_MIN || 32'(cfg_dbits) > DBIT_MAX) dbits_c = 4'(DBIT_MAX);
        case (cfg_parity)
            PAR_EVEN: par_en_c = 1'b1;
            PAR_ODD: begin
                par_en_c  = 1'b1;
                par_odd_c = 1'b1;
            end
            PAR_NONE: par_en_c = 1'b0;
            default:  par_en_c = 1'b0;
        endcase
        cfg_c.dbits   = dbits_c;
        cfg_c.par_en  = par_en_c;
        cfg_c.par_bit = data_xor(din, dbits_c) ^ par_odd_c;
        cfg_c.stop    = cfg_stop;
    end

    assign hold_valid_c = ~tx_ready;
    assign tx_ovf_tick  = tx_start & ~tx_ready;

    // Write and drain never coincide: drain needs a full register, write an empty one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ready  <= 1'b1;
            hold_data <= '0;
            hold_cfg  <= '0;
        end else if (tx_start && tx_ready) begin
            tx_ready  <= 1'b0;
            hold_data <= din;
            hold_cfg  <= cfg_c;
        end else if (drain) begin
            tx_ready  <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DBIT_MAX data bits, optional parity,
// 1/1.5/2 stop bits, back-to-back frames fed from a one-entry holding register.
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int unsigned DBIT_MAX = 8,
    parameter int unsigned OVS      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic [1:0]          cfg_stop,
    input  logic                tx_start,
    input  logic [DBIT_MAX-1:0] din,
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                tx_done_tick,
    output logic                tx_ovf_tick,
    output logic                tx
);

    localparam int unsigned SW = $clog2(2 * OVS);
    localparam int unsigned NW = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;
    localparam logic [SW-1:0] S_BIT_LAST = SW'(OVS - 1);

    tx_state_t           state, state_n;
    logic [SW-1:0]       s_cnt, s_n;
    logic [NW-1:0]       n_cnt, n_n;
    logic [DBIT_MAX-1:0] shift, shift_n;
    frame_cfg_t          cur_cfg, cfg_n;
    logic                tx_n, done_n, load;
    logic                hold_valid_c;
    logic [DBIT_MAX-1:0] hold_data;
    frame_cfg_t          hold_cfg;

    uart_tx_hold #(.DBIT_MAX(DBIT_MAX)) u_hold (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .cfg_dbits    (cfg_dbits),
        .cfg_parity   (cfg_parity),
        .cfg_stop     (cfg_stop),
        .din          (din),
        .drain        (load),
        .hold_valid_c (hold_valid_c),
        .hold_data    (hold_data),
        .hold_cfg     (hold_cfg),
        .tx_ready     (tx_ready),
        .tx_ovf_tick  (tx_ovf_tick)
    );

    function automatic logic [SW-1:0] stop_last(input logic [1:0] stop);
        case (stop)
            STOP_1:   return SW'(OVS - 1);
            STOP_1P5: return SW'((3 * OVS) / 2 - 1);
            STOP_2:   return SW'(2 * OVS - 1);
            default:  return SW'(2 * OVS - 1);
        endcase
    endfunction

    // Next state; tx_n is driven from the current state so the line lags the FSM by one clk
    always_comb begin
        state_n = state;
        s_n     = s_cnt;
        n_n     = n_cnt;
        shift_n = shift;
        cfg_n   = cur_cfg;
        tx_n    = 1'b1;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            ST_IDLE: load = hold_valid_c;
            ST_START: begin
                tx_n = 1'b0;
                if (s_tick) begin
                    if (s_cnt == S_BIT_LAST) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = ST_DATA;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                tx_n = shift[0];
                if (s_tick) begin
                    if (s_cnt == S_BIT_LAST) begin
                        s_n     = '0;
                        shift_n = shift >> 1;
                        if (n_cnt == NW'(cur_cfg.dbits - 4'd1))
                            state_n = cur_cfg.par_en ? ST_PARITY : ST_STOP;
                        else
                            n_n = n_cnt + 1'b1;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_n = cur_cfg.par_bit;
                if (s_tick) begin
                    if (s_cnt == S_BIT_LAST) begin
                        s_n     = '0;
                        state_n = ST_STOP;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_cnt == stop_last(cur_cfg.stop)) begin
                        done_n  = 1'b1;
                        s_n     = '0;
                        state_n = ST_IDLE;
                        load    = hold_valid_c;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // A pending frame follows the stop period directly, without an idle bit
        if (load) begin
            shift_n = hold_data;
            cfg_n   = hold_cfg;
            s_n     = '0;
            state_n = ST_START;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift        <= '0;
            cur_cfg      <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s_cnt        <= s_n;
            n_cnt        <= n_n;
            shift        <= shift_n;
            cur_cfg      <= cfg_n;
            tx           <= tx_n;
            tx_busy      <= (state_n != ST_IDLE);
            tx_done_tick <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frame-level reference model checked every cycle,
// plus directed frames decoded from the serial line against literal bit patterns.
module tb_uart_tx_cfg;

    localparam int OVS      = 16;
    localparam int DBIT_MAX = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic [3:0] cfg_dbits = 4'd8;
    logic [1:0] cfg_parity = 2'd0;
    logic [1:0] cfg_stop = 2'd0;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_ready, tx_busy, tx_done_tick, tx_ovf_tick, tx;

    int checks = 0;
    int errors = 0;
    int tick_mode = 0;
    int tick_ph = 0;

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .cfg_dbits    (cfg_dbits),
        .cfg_parity   (cfg_parity),
        .cfg_stop     (cfg_stop),
        .tx_start     (tx_start),
        .din          (din),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx_ovf_tick  (tx_ovf_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    // Oversampling tick: periodic every 4th clk, random, or stalled
    initial forever begin
        @(posedge clk);
        #1;
        tick_ph = (tick_ph + 1) % 4;
        case (tick_mode)
            0:       s_tick = (tick_ph == 0);
            1:       s_tick = 1'($urandom_range(0, 1));
            default: s_tick = 1'b0;
        endcase
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        int         dbits;
        bit         pe;
        bit         pbit;
        int         stop_len;
    } frame_t;

    frame_t m_cur, m_hold;
    bit     m_active = 0;
    bit     m_hold_v = 0;
    bit     pre_v;
    int     m_t = 0;
    logic   m_tx = 1'b1;
    logic   m_busy = 1'b0;
    logic   m_done = 1'b0;

    function automatic frame_t mk_frame(logic [7:0] d, logic [3:0] nb, logic [1:0] par, logic [1:0] st);
        frame_t f;
        int ones;
        f.data  = d;
        f.dbits = (nb >= 5 && nb <= DBIT_MAX) ? int'(nb) : DBIT_MAX;
        f.pe    = (par == 2'd1 || par == 2'd2);
        ones = 0;
        for (int i = 0; i < f.dbits; i++) ones += int'(d[i]);
        f.pbit = (par == 2'd2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        f.stop_len = (st == 2'd0) ? OVS : (st == 2'd1) ? (3 * OVS) / 2 : 2 * OVS;
        return f;
    endfunction

    function automatic int frame_len(frame_t f);
        return OVS * (1 + f.dbits + int'(f.pe)) + f.stop_len;
    endfunction

    // Line level at tick offset t within a frame
    function automatic logic line_bit(frame_t f, int t);
        int p;
        p = t / OVS;
        if (p == 0) return 1'b0;
        if (p <= f.dbits) return f.data[p-1];
        if (f.pe && p == f.dbits + 1) return 1'(f.pbit);
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_active = 0;
            m_hold_v = 0;
            m_t      = 0;
            m_tx     = 1'b1;
            m_busy   = 1'b0;
            m_done   = 1'b0;
        end else begin
            pre_v  = m_hold_v;
            m_tx   = m_active ? line_bit(m_cur, m_t) : 1'b1;
            m_done = 1'b0;
            if (m_active && s_tick) begin
                if (m_t == frame_len(m_cur) - 1) begin
                    m_done   = 1'b1;
                    m_active = 0;
                end else begin
                    m_t++;
                end
            end
            if (!m_active && pre_v) begin
                m_cur    = m_hold;
                m_hold_v = 0;
                m_active = 1;
                m_t      = 0;
            end
            if (tx_start && !pre_v) begin
                m_hold   = mk_frame(din, cfg_dbits, cfg_parity, cfg_stop);
                m_hold_v = 1;
            end
            m_busy = 1'(m_active);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("tx", {31'b0, tx}, {31'b0, m_tx});
        check("tx_ready", {31'b0, tx_ready}, {31'b0, ~m_hold_v});
        check("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy});
        check("tx_done_tick", {31'b0, tx_done_tick}, {31'b0, m_done});
        check("tx_ovf_tick", {31'b0, tx_ovf_tick}, {31'b0, tx_start & m_hold_v});
    end

    // ---------------- directed helpers ----------------
    task automatic fail_timeout(input string name, input logic act, input logic exp);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got %b expected %b", name, act, exp);
    endtask

    task automatic write_frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par, input logic [1:0] st);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = tx_ready;
        end
        if (!ok) fail_timeout("write_ready", tx_ready, 1'b1);
        din = d; cfg_dbits = nb; cfg_parity = par; cfg_stop = st;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        din = 8'($urandom); cfg_dbits = 4'($urandom); cfg_parity = 2'($urandom); cfg_stop = 2'($urandom);
    endtask

    task automatic wait_tx_low(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1;
        end
        if (!ok) fail_timeout(name, tx, 1'b0);
    endtask

    task automatic wait_done(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) ok = 1;
        end
        if (!ok) fail_timeout(name, tx_done_tick, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0 && tx_ready === 1'b1) ok = 1;
        end
        if (!ok) fail_timeout(name, tx_busy, 1'b0);
    endtask

    // Sample the line mid-bit (64 clk per bit with periodic ticks), bit k of exp first-sent first
    task automatic decode(input string name, input int nbits, input logic [31:0] exp);
        bit ok;
        wait_tx_low(name, ok);
        if (ok) begin
            repeat (32) @(negedge clk);
            for (int k = 0; k < nbits; k++) begin
                check($sformatf("%s_bit%0d", name, k), {31'b0, tx}, {31'b0, exp[k]});
                if (k != nbits - 1) repeat (64) @(negedge clk);
            end
        end
    endtask

    // Clocks between consecutive done pulses of back-to-back frames
    task automatic done_gap(input string name, input int exp);
        bit ok;
        int n;
        n = 0;
        wait_done(name, ok);
        if (ok) begin
            for (int i = 1; i < 4000 && n == 0; i++) begin
                @(negedge clk);
                if (tx_done_tick === 1'b1) n = i;
            end
            check(name, 32'(n), 32'(exp));
        end
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_busy", {31'b0, tx_busy}, 32'd0);
        check("rst_done", {31'b0, tx_done_tick}, 32'd0);
        check("rst_ovf", {31'b0, tx_ovf_tick}, 32'd0);

        // 8N1 0xA5
        fork
            decode("t1_8n1_a5", 10, {1'b1, 8'hA5, 1'b0});
            write_frame(8'hA5, 4'd8, 2'd0, 2'd0);
        join
        wait_idle("t1_idle");

        // 7E1 and 7O2 on data 0x03
        fork
            decode("t2_7e1", 10, {1'b1, 1'b0, 7'h03, 1'b0});
            write_frame(8'h03, 4'd7, 2'd1, 2'd0);
        join
        wait_idle("t2_idle_a");
        fork
            decode("t2_7o2", 11, {2'b11, 1'b1, 7'h03, 1'b0});
            begin
                write_frame(8'h03, 4'd7, 2'd2, 2'd2);
                write_frame(8'h03, 4'd7, 2'd2, 2'd2);
            end
        join
        done_gap("t2_7o2_gap", 704);
        wait_idle("t2_idle_b");

        // 5N1.5 frames are 120 ticks; out-of-range widths fall back to 8 bits
        write_frame(8'h15, 4'd5, 2'd0, 2'd1);
        write_frame(8'h0A, 4'd5, 2'd0, 2'd1);
        done_gap("t3_5n15_gap", 480);
        wait_idle("t3_idle_a");
        fork
            decode("t3_dbits4", 10, {1'b1, 8'h5A, 1'b0});
            write_frame(8'h5A, 4'd4, 2'd0, 2'd0);
        join
        wait_idle("t3_idle_b");
        fork
            decode("t3_dbits9", 10, {1'b1, 8'hC3, 1'b0});
            write_frame(8'hC3, 4'd9, 2'd0, 2'd0);
        join
        wait_idle("t3_idle_c");

        // Back-to-back frames and a dropped third write
        fork
            decode("t4_pair", 20, {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
            begin
                write_frame(8'h11, 4'd8, 2'd0, 2'd0);
                write_frame(8'h22, 4'd8, 2'd0, 2'd0);
                din = 8'h33; cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop = 2'd0;
                tx_start = 1'b1;
                #1;
                check("t4_ovf", {31'b0, tx_ovf_tick}, 32'd1);
                @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
        join
        wait_idle("t4_idle");

        // Reset during data bit 3
        write_frame(8'hF0, 4'd8, 2'd0, 2'd0);
        wait_tx_low("t5_start", ok);
        repeat (288) @(negedge clk);
        check("t5_pre_reset_tx", {31'b0, tx}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t5_reset_tx", {31'b0, tx}, 32'd1);
        check("t5_reset_ready", {31'b0, tx_ready}, 32'd1);
        check("t5_reset_busy", {31'b0, tx_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        fork
            decode("t5_after", 10, {1'b1, 8'h3C, 1'b0});
            write_frame(8'h3C, 4'd8, 2'd0, 2'd0);
        join
        wait_idle("t5_idle");

        // Tick stall mid-data
        write_frame(8'h96, 4'd8, 2'd1, 2'd2);
        wait_tx_low("t6_start", ok);
        repeat (150) @(negedge clk);
        tick_mode = 2;
        repeat (100) @(negedge clk);
        check("t6_frozen_busy", {31'b0, tx_busy}, 32'd1);
        tick_mode = 0;
        wait_done("t6_done", ok);
        wait_idle("t6_idle");

        // Random traffic, random tick spacing, cfg changing every cycle
        tick_mode = 1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            #1;
            tx_start   = ($urandom_range(0, 149) == 0);
            din        = 8'($urandom);
            cfg_dbits  = 4'($urandom);
            cfg_parity = 2'($urandom);
            cfg_stop   = 2'($urandom);
        end
        tx_start  = 1'b0;
        tick_mode = 0;
        wait_idle("rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
